// File: rtl/frame_collector_32_if.sv
// frame_collector_32_if
//   Bundles the beat input, the frame output and the downstream ready of
//   frame_collector_32. The clock and the reset are not part of the bundle.
//
//   Handshake: a beat on i_data moves into the collector at a rising edge
//   where i_valid=1 and o_ready=1. o_ready is a registered value and holds
//   for the whole cycle. A beat offered while o_ready=0 is dropped, and
//   o_drop is set. On the output side, o_valid is a one-cycle strobe. A
//   strobe is raised only at an edge where i_ds_ready=1 and o_valid was 0.
//
//   Signals
//     i_data      LANES_IN*NB_DATA   beat; lane j = [j*NB_DATA +: NB_DATA]
//     i_valid     1                  beat present
//     o_ready     1                  collector accepts a beat this cycle
//     i_ds_ready  1                  downstream stride stage idle
//     o_frame     FRAME_SIZE*NB_DATA frame; sample k = [k*NB_DATA +: NB_DATA]
//     o_valid     1                  one-cycle frame launch strobe
//     o_drop      1                  sticky: beat offered while o_ready=0
//     o_dbg_state 4                  {bank1 state, bank0 state}
//     i_flush     1                  only with FRAME_COLLECT_FLUSH_EN
//
//   Modports: master drives the beats (the source/bench side).
//             slave is the collector side.
interface frame_collector_32_if #(
  parameter int NB_DATA    = 16,
  parameter int LANES_IN   = 4,
  parameter int FRAME_SIZE = 32
);
  logic [LANES_IN*NB_DATA-1:0]   i_data;
  logic                          i_valid;
  logic                          o_ready;
  logic                          i_ds_ready;
  logic [FRAME_SIZE*NB_DATA-1:0] o_frame;
  logic                          o_valid;
  logic                          o_drop;
  logic [3:0]                    o_dbg_state;
`ifdef FRAME_COLLECT_FLUSH_EN
  logic                          i_flush;

  modport master (
    output i_data, i_valid, i_ds_ready, i_flush,
    input  o_ready, o_frame, o_valid, o_drop, o_dbg_state
  );
  modport slave (
    input  i_data, i_valid, i_ds_ready, i_flush,
    output o_ready, o_frame, o_valid, o_drop, o_dbg_state
  );
`else
  modport master (
    output i_data, i_valid, i_ds_ready,
    input  o_ready, o_frame, o_valid, o_drop, o_dbg_state
  );
  modport slave (
    input  i_data, i_valid, i_ds_ready,
    output o_ready, o_frame, o_valid, o_drop, o_dbg_state
  );
`endif
endinterface

// File: rtl/frame_collector_32.sv
// frame_collector_32
//   Packs a stream of 4-sample beats into 32-sample frames. The frames are
//   held in a ping-pong buffer with two banks. Each full frame goes to the
//   8-stride reorder stage as a one-cycle o_valid pulse. Samples pass
//   through unchanged.
//
//   Ports
//     i_clk    single clock; all logic runs on the rising edge
//     i_rst_n  synchronous reset, active-low
//     bus      frame_collector_32_if.slave (beats in, frames out)
//
//   Optional feature: define FRAME_COLLECT_FLUSH_EN to add bus.i_flush.
//   A flush closes a partly filled bank early and zero-pads the samples
//   that were not written.
//
//   Each bank has its own state machine: EMPTY -> FILLING -> FULL -> EMPTY.
//   bus.o_dbg_state shows the state of both banks.
module frame_collector_32 #(
  parameter int NB_DATA    = 16,
  parameter int LANES_IN   = 4,
  parameter int FRAME_SIZE = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  frame_collector_32_if.slave  bus
);

  typedef enum logic [1:0] {
    B_EMPTY   = 2'd0,
    B_FILLING = 2'd1,
    B_FULL    = 2'd2
  } bank_state_t;

  bank_state_t                   bs_q [2];
  bank_state_t                   bs_n [2];
  logic                          wr_bank_q, wr_bank_n;
  logic                          rd_bank_q, rd_bank_n;
  logic [2:0]                    beat_cnt_q, beat_cnt_n;
  logic                          ready_q, ready_n;
  logic                          valid_q, valid_n;
  logic                          drop_q, drop_n;
  logic [FRAME_SIZE*NB_DATA-1:0] frame_q, rd_frame;
  logic [NB_DATA-1:0]            mem [2][FRAME_SIZE];

  logic                          accept, launch, wrap, flush_req, flush_go;
  logic [2:0]                    cnt_after;
  logic [4:0]                    pad_base;

`ifdef FRAME_COLLECT_FLUSH_EN
  assign flush_req = bus.i_flush;
`else
  assign flush_req = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      bs_q[0]    <= B_EMPTY;
      bs_q[1]    <= B_EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      beat_cnt_q <= 3'd0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
      frame_q    <= '0;
    end else begin
      bs_q[0]    <= bs_n[0];
      bs_q[1]    <= bs_n[1];
      wr_bank_q  <= wr_bank_n;
      rd_bank_q  <= rd_bank_n;
      beat_cnt_q <= beat_cnt_n;
      ready_q    <= ready_n;
      valid_q    <= valid_n;
      drop_q     <= drop_n;
      if (launch) frame_q <= rd_frame;
    end
  end

  // Next state
  always_comb begin
    accept = bus.i_valid & ready_q;
    // Holdoff on valid_q: downstream lowers its ready one cycle after it
    // accepts a frame, so we must not launch again in that cycle.
    launch = (bs_q[rd_bank_q] == B_FULL) & bus.i_ds_ready & ~valid_q;
    wrap   = accept & (beat_cnt_q == 3'd7);
    cnt_after = accept ? beat_cnt_q + 3'd1 : beat_cnt_q;
    // A flush only acts on a bank that is still partly filled after this
    // edge's beat. When the 8th beat lands, cnt_after is already 0.
    flush_go = flush_req & (cnt_after != 3'd0);
    pad_base = {cnt_after, 2'b00};

    bs_n[0] = bs_q[0];
    bs_n[1] = bs_q[1];
    // Launch and accept never hit the same bank. Accept needs wr_bank to be
    // not FULL, and launch needs rd_bank to be FULL.
    if (launch)   bs_n[rd_bank_q] = B_EMPTY;
    if (accept)   bs_n[wr_bank_q] = wrap ? B_FULL : B_FILLING;
    if (flush_go) bs_n[wr_bank_q] = B_FULL;

    beat_cnt_n = flush_go ? 3'd0 : cnt_after;
    wr_bank_n  = wr_bank_q ^ (wrap | flush_go);
    rd_bank_n  = rd_bank_q ^ launch;
    // Ready looks at the bank that will be written next, after this edge.
    ready_n    = (bs_n[wr_bank_n] != B_FULL);
    valid_n    = launch;
    drop_n     = drop_q | (bus.i_valid & ~ready_q);
  end

  // Outputs
  always_comb begin
    rd_frame = '0;
    for (int k = 0; k < FRAME_SIZE; k++) begin
      rd_frame[k*NB_DATA +: NB_DATA] = mem[rd_bank_q][k];
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_drop      = drop_q;
  assign bus.o_frame     = frame_q;
  assign bus.o_dbg_state = {bs_q[1], bs_q[0]};

  // Bank storage. It needs no reset, because every sample of a bank is
  // rewritten or zero-padded before that bank can be launched.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      for (int k = 0; k < FRAME_SIZE; k++) begin
        if (flush_go && (k >= int'(pad_base))) mem[wr_bank_q][k] <= '0;
      end
      if (accept) begin
        for (int j = 0; j < LANES_IN; j++) begin
          mem[wr_bank_q][{beat_cnt_q, 2'(j)}] <= bus.i_data[j*NB_DATA +: NB_DATA];
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_collector_32.sv
// tb_frame_collector_32
//   Bench for frame_collector_32. A negedge monitor rebuilds the frames from
//   the beats the collector accepts. It queues each expected frame and checks
//   it against the frame that is launched. Directed steps check reset values,
//   latency, back-pressure, drops, reset mid-frame and flush. A random phase
//   at the end checks long-run ordering.
module tb_frame_collector_32;
  localparam int NB = 16;
  localparam int LW = 4 * NB;
  localparam int FW = 32 * NB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_collector_32_if bus ();
  frame_collector_32 dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  // i_ds_ready comes either from the bench directly or from the stride model
  logic ds_manual = 1'b0;
  logic ds_model  = 1'b1;
  logic stride_mode = 1'b0;
  int   busy = 0;
  assign bus.i_ds_ready = stride_mode ? ds_model : ds_manual;

  int n_vec = 0;
  int n_err = 0;
  int n_launch = 0;
  int n_acc = 0;

  // Scoreboard state
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] cur_frame = '0;
  int            cur_cnt = 0;
  logic          prev_valid = 1'b0;
  logic          prev_ds = 1'b0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stride stage model: it stays busy 9 cycles after each frame it accepts
  always @(posedge clk) begin
    #1;
    if (!stride_mode)      busy = 0;
    else if (bus.o_valid)  busy = 9;
    else if (busy != 0)    busy--;
    ds_model = (busy == 0);
  end

  // Monitor and scoreboard
  always @(negedge clk) begin
    if (bus.o_valid) begin
      n_launch++;
      check("holdoff", prev_valid, 1'b0);
      check("ds_ready_at_launch", prev_ds, 1'b1);
      check("frame_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("frame", bus.o_frame, exp_q.pop_front());
    end
    prev_valid = bus.o_valid;
    prev_ds    = bus.i_ds_ready;
    if (!rst_n) begin
      cur_cnt = 0;
      exp_q.delete();
    end else begin
      if (bus.i_valid && bus.o_ready) begin
        cur_frame[cur_cnt*LW +: LW] = bus.i_data;
        cur_cnt++;
        n_acc++;
        if (cur_cnt == 8) begin
          exp_q.push_back(cur_frame);
          cur_cnt = 0;
        end
      end
`ifdef FRAME_COLLECT_FLUSH_EN
      if (bus.i_flush && cur_cnt != 0) begin
        for (int k = cur_cnt * 4; k < 32; k++) cur_frame[k*NB +: NB] = '0;
        exp_q.push_back(cur_frame);
        cur_cnt = 0;
      end
`endif
    end
  end

  // Driver: wait for o_ready, then present the beat for one cycle
  task automatic send_beat(input logic [LW-1:0] d);
    int n;
    n = 0;
    while (!bus.o_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("send_ready_timeout", bus.o_ready, 1'b1);
    bus.i_data  = d;
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  function automatic logic [LW-1:0] idx_beat(input int b);
    logic [LW-1:0] d;
    for (int j = 0; j < 4; j++) d[j*NB +: NB] = 16'(b * 4 + j);
    return d;
  endfunction

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) begin @(posedge clk); #1; end
    rst_n = 1'b1;
  endtask

  task automatic wait_launches(input int target);
    for (int i = 0; i < 300 && n_launch < target; i++) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [FW-1:0] exp_t1;
    int acc0;
    for (int k = 0; k < 32; k++) exp_t1[k*NB +: NB] = 16'(k);
    bus.i_data  = '0;
    bus.i_valid = 1'b0;
`ifdef FRAME_COLLECT_FLUSH_EN
    bus.i_flush = 1'b0;
`endif

    // Reset values
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_ready", bus.o_ready, 1'b1);
    check("rst_frame", bus.o_frame, '0);
    check("rst_drop",  bus.o_drop,  1'b0);
    rst_n = 1'b1;

    // T1: one frame of sample indices, downstream idle
    ds_manual = 1'b1;
    for (int b = 0; b < 8; b++) send_beat(idx_beat(b));
    check("t1_valid_k1", bus.o_valid, 1'b0);
    @(posedge clk); #1;
    check("t1_valid_k2", bus.o_valid, 1'b1);
    check("t1_frame",    bus.o_frame, exp_t1);
    check("t1_ready",    bus.o_ready, 1'b1);
    @(posedge clk); #1;
    check("t1_valid_k3", bus.o_valid, 1'b0);

    // T2: downstream blocked, both banks fill, then the overflow beat drops
    ds_manual = 1'b0;
    for (int b = 0; b < 16; b++) send_beat({$urandom, $urandom});
    check("t2_ready_full", bus.o_ready, 1'b0);
    bus.i_data  = {$urandom, $urandom};
    bus.i_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    check("t2_drop",     bus.o_drop,  1'b1);
    check("t2_no_launch", bus.o_valid, 1'b0);
    ds_manual = 1'b1;
    @(posedge clk); #1;
    check("t2_launch0",  bus.o_valid, 1'b1);
    check("t2_ready_back", bus.o_ready, 1'b1);
    @(posedge clk); #1;
    check("t2_holdoff",  bus.o_valid, 1'b0);
    @(posedge clk); #1;
    check("t2_launch1",  bus.o_valid, 1'b1);
    @(posedge clk); #1;

    // T3: stride model as downstream, 64 continuous beats
    do_reset(2);
    n_launch = 0;
    stride_mode = 1'b1;
    for (int b = 0; b < 64; b++) send_beat({$urandom, $urandom});
    wait_launches(8);
    repeat (12) begin @(posedge clk); #1; end
    check("t3_launches", n_launch, 8);
    check("t3_no_drop",  bus.o_drop, 1'b0);
    check("t3_q_empty",  exp_q.size(), 0);
    stride_mode = 1'b0;

    // T4: reset after 5 beats; only the new frame may launch
    ds_manual = 1'b1;
    for (int b = 0; b < 5; b++) send_beat({$urandom, $urandom});
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t4_rst_valid", bus.o_valid, 1'b0);
    check("t4_rst_ready", bus.o_ready, 1'b1);
    check("t4_rst_frame", bus.o_frame, '0);
    check("t4_rst_drop",  bus.o_drop,  1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_launch = 0;
    for (int b = 0; b < 8; b++) send_beat({$urandom, $urandom});
    wait_launches(1);
    repeat (6) begin @(posedge clk); #1; end
    check("t4_launches", n_launch, 1);
    check("t4_q_empty",  exp_q.size(), 0);

`ifdef FRAME_COLLECT_FLUSH_EN
    // T5: three beats of 0xAAAA, then flush
    begin
      logic [FW-1:0] exp_t5;
      exp_t5 = '0;
      for (int k = 0; k < 12; k++) exp_t5[k*NB +: NB] = 16'hAAAA;
      n_launch = 0;
      for (int b = 0; b < 3; b++) send_beat({4{16'hAAAA}});
      bus.i_flush = 1'b1;
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      for (int i = 0; i < 10 && !bus.o_valid; i++) begin @(posedge clk); #1; end
      check("t5_flush_valid", bus.o_valid, 1'b1);
      check("t5_flush_frame", bus.o_frame, exp_t5);
      for (int b = 0; b < 8; b++) send_beat(idx_beat(b));
      for (int i = 0; i < 10 && !bus.o_valid; i++) begin @(posedge clk); #1; end
      check("t5_next_frame", bus.o_frame, exp_t1);
      @(posedge clk); #1;
    end
`endif

    // T6: random valid and random downstream ready, 10k accepted beats
    acc0 = n_acc;
    for (int c = 0; c < 60000 && (n_acc - acc0) < 10000; c++) begin
      bus.i_valid = 1'($urandom_range(0, 1));
      bus.i_data  = {$urandom, $urandom};
      ds_manual   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.i_valid = 1'b0;
    ds_manual = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    repeat (4) begin @(posedge clk); #1; end
    check("t6_accepted", n_acc - acc0, 10000);
    check("t6_q_empty",  exp_q.size(), 0);
    check("t6_partial",  cur_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
